alu_result_serializer: RTL and testbench

ALU_RESULT_SERIALIZER -- requirements
Module: alu_result_serializer

---
 rtl/alu_result_serializer.sv | 125 ++++++++++++
 tb/tb_alu_result_serializer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_serializer.sv
// Captures one ALU result snapshot into a 24-bit frame and streams it MSB first
// over a valid/ready serial link, optionally followed by an even-parity bit.
module alu_result_serializer #(
  parameter bit PARITY_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cap_valid,
  output logic       cap_ready,
  input  logic       Sum,
  input  logic       Carry,
  input  logic       Diff,
  input  logic       Bout,
  input  logic       Mux_out,
  input  logic       Storing,
  input  logic       AND,
  input  logic       OR,
  input  logic       NOT,
  input  logic       XOR,
  input  logic       XNOR,
  input  logic       NAND,
  input  logic       NOR,
  input  logic [3:0] Product,
  input  logic [3:0] Decoder_Y,
  output logic       ser_data,
  output logic       ser_valid,
  output logic       ser_last,
  input  logic       ser_ready,
  output logic       busy,
  output logic [7:0] frame_cnt,
  output logic [1:0] dbg_state
);

  // Handshake: a bit moves on any rising edge where ser_valid && ser_ready;
  // a snapshot is taken on any rising edge where cap_valid && cap_ready.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [23:0] shreg_q;
  logic [4:0]  bit_cnt_q;
  logic        par_q;
  logic [2:0]  tag_q;
  logic [7:0]  frame_cnt_q;
  logic [23:0] frame_in;
  logic        capture;
  logic        frame_done;

  assign frame_in = {tag_q, Product, Decoder_Y, Sum, Carry, Diff, Bout,
                     AND, OR, NOT, XOR, XNOR, NAND, NOR, Mux_out, Storing};
  assign capture  = (state_q == IDLE) && cap_valid;

  always_comb begin
    state_d    = state_q;
    frame_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (cap_valid) state_d = SHIFT;
      end
      SHIFT: begin
        if (ser_ready && (bit_cnt_q == 5'd0)) begin
          if (PARITY_EN) begin
            state_d = PAR;
          end else begin
            state_d    = IDLE;
            frame_done = 1'b1;
          end
        end
      end
      PAR: begin
        if (ser_ready) begin
          state_d    = IDLE;
          frame_done = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Parity is latched at capture so later input changes cannot disturb it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      par_q       <= 1'b0;
      tag_q       <= '0;
      frame_cnt_q <= '0;
    end else begin
      if (capture) begin
        shreg_q   <= frame_in;
        bit_cnt_q <= 5'd23;
        par_q     <= ^frame_in;
      end else if ((state_q == SHIFT) && ser_ready && (bit_cnt_q != 5'd0)) begin
        shreg_q   <= {shreg_q[22:0], 1'b0};
        bit_cnt_q <= bit_cnt_q - 5'd1;
      end
      if (frame_done) begin
        frame_cnt_q <= frame_cnt_q + 8'd1;
        tag_q       <= tag_q + 3'd1;
      end
    end
  end

  assign cap_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign ser_valid = (state_q != IDLE);
  assign ser_data  = (state_q == SHIFT) ? shreg_q[23] :
                     (state_q == PAR)   ? par_q       : 1'b0;
  assign ser_last  = (state_q == PAR) ||
                     ((state_q == SHIFT) && (bit_cnt_q == 5'd0) && !PARITY_EN);
  assign frame_cnt = frame_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_result_serializer.sv
// Directed-plus-random bench for alu_result_serializer: a frame-level model
// builds expected bit streams which a negedge monitor's captures are checked against.
module tb_alu_result_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, cap_valid, cap_ready, ser_data, ser_valid, ser_last, ser_ready, busy;
  logic [7:0] frame_cnt;
  logic [1:0] dbg_state;
  logic       cap_valid_np, cap_ready_np, ser_data_np, ser_valid_np, ser_last_np, busy_np;
  logic       ser_ready_np;
  logic [7:0] frame_cnt_np;
  logic [1:0] dbg_state_np;
  logic [3:0] product, decoder_y;
  logic [12:0] flags;

  int compared = 0;
  int mismatched = 0;
  logic [2:0] tag_m;
  logic [7:0] fcnt_m;
  logic [1:0] rx_q[$];
  logic [1:0] rx_np_q[$];
  logic [1:0] exp_q[$];
  logic       hold_pend = 1'b0;
  logic [1:0] hold_bits = 2'b00;

  alu_result_serializer #(.PARITY_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .cap_valid(cap_valid), .cap_ready(cap_ready),
    .Sum(flags[12]), .Carry(flags[11]), .Diff(flags[10]), .Bout(flags[9]),
    .Mux_out(flags[1]), .Storing(flags[0]), .AND(flags[8]), .OR(flags[7]),
    .NOT(flags[6]), .XOR(flags[5]), .XNOR(flags[4]), .NAND(flags[3]), .NOR(flags[2]),
    .Product(product), .Decoder_Y(decoder_y),
    .ser_data(ser_data), .ser_valid(ser_valid), .ser_last(ser_last), .ser_ready(ser_ready),
    .busy(busy), .frame_cnt(frame_cnt), .dbg_state(dbg_state)
  );

  alu_result_serializer #(.PARITY_EN(1'b0)) dut_np (
    .clk(clk), .rst_n(rst_n), .cap_valid(cap_valid_np), .cap_ready(cap_ready_np),
    .Sum(flags[12]), .Carry(flags[11]), .Diff(flags[10]), .Bout(flags[9]),
    .Mux_out(flags[1]), .Storing(flags[0]), .AND(flags[8]), .OR(flags[7]),
    .NOT(flags[6]), .XOR(flags[5]), .XNOR(flags[4]), .NAND(flags[3]), .NOR(flags[2]),
    .Product(product), .Decoder_Y(decoder_y),
    .ser_data(ser_data_np), .ser_valid(ser_valid_np), .ser_last(ser_last_np),
    .ser_ready(ser_ready_np), .busy(busy_np), .frame_cnt(frame_cnt_np), .dbg_state(dbg_state_np)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: record every accepted bit and confirm stalled bits do not move.
  always @(negedge clk) begin
    if (rst_n && ser_valid && ser_ready) rx_q.push_back({ser_last, ser_data});
    if (rst_n && ser_valid_np && ser_ready_np) rx_np_q.push_back({ser_last_np, ser_data_np});
    if (rst_n && hold_pend && ser_valid)
      check("hold_stable", {30'd0, ser_last, ser_data}, {30'd0, hold_bits});
    hold_pend = rst_n && ser_valid && !ser_ready;
    hold_bits = {ser_last, ser_data};
  end

  task automatic scramble_inputs();
    product   = 4'($urandom_range(0, 15));
    decoder_y = 4'($urandom_range(0, 15));
    flags     = 13'($urandom_range(0, 8191));
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0; cap_valid = 1'b0; cap_valid_np = 1'b0; ser_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tag_m = 3'd0; fcnt_m = 8'd0;
    rx_q.delete(); rx_np_q.delete(); exp_q.delete();
  endtask

  task automatic compare_queue(input string tag);
    check({tag, "_len"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      check(tag, {30'd0, rx_q[i]}, {30'd0, exp_q[i]});
    rx_q.delete(); exp_q.delete();
  endtask

  task automatic pack_rx(input int field, output logic [24:0] v);
    v = '0;
    for (int i = 0; i < rx_q.size() && i < 25; i++) v[24-i] = rx_q[i][field];
  endtask

  // One frame: capture, drain with the chosen ser_ready pattern, compare to model.
  task automatic run_frame(input logic [3:0] p, input logic [3:0] d, input logic [12:0] f,
                           input int bp, output logic [24:0] got);
    logic [23:0] fr;
    int cyc;
    rx_q.delete(); exp_q.delete();
    @(negedge clk);
    product = p; decoder_y = d; flags = f; cap_valid = 1'b1; ser_ready = 1'b1;
    fr = {tag_m, p, d, f};
    for (int i = 23; i >= 0; i--) exp_q.push_back({1'b0, fr[i]});
    exp_q.push_back({1'b1, ^fr});
    @(posedge clk); #1;
    cap_valid = 1'b0;
    scramble_inputs();
    check("first_valid", {31'd0, ser_valid}, 32'd1);
    check("first_bit", {31'd0, ser_data}, {31'd0, fr[23]});
    cyc = 0;
    while (rx_q.size() < 25 && cyc < 400) begin
      case (bp)
        0:       ser_ready = 1'b1;
        1:       ser_ready = ((cyc % 4) == 1 || (cyc % 4) == 2) ? 1'b0 : 1'b1;
        default: ser_ready = 1'($urandom_range(0, 1));
      endcase
      cap_valid = (rx_q.size() < 20) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    cap_valid = 1'b0; ser_ready = 1'b1;
    check("frame_timeout", {31'd0, cyc < 400}, 32'd1);
    pack_rx(0, got);
    compare_queue("frame_bit");
    tag_m++; fcnt_m++;
    check("frame_cnt", {24'd0, frame_cnt}, {24'd0, fcnt_m});
    check("cap_ready_after", {31'd0, cap_ready}, 32'd1);
    check("busy_after", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [24:0] got, got_b, lasts;
    logic [23:0] fr, np_bits, np_last;
    logic [3:0] p, d;
    logic [12:0] f;
    int n;

    rst_n = 1'b0; cap_valid = 1'b0; cap_valid_np = 1'b0; ser_ready = 1'b1; ser_ready_np = 1'b1;
    product = '0; decoder_y = '0; flags = '0;
    tag_m = 3'd0; fcnt_m = 8'd0;
    #2;
    check("rst_cap_ready", {31'd0, cap_ready}, 32'd1);
    check("rst_ser_valid", {31'd0, ser_valid}, 32'd0);
    check("rst_ser_data", {31'd0, ser_data}, 32'd0);
    check("rst_ser_last", {31'd0, ser_last}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_frame_cnt", {24'd0, frame_cnt}, 32'd0);

    // All-zero frame captured on the first edge after release.
    @(negedge clk);
    rst_n = 1'b1; cap_valid = 1'b1;
    @(posedge clk); #1;
    cap_valid = 1'b0;
    check("zero_busy", {31'd0, busy}, 32'd1);
    check("zero_cap_ready", {31'd0, cap_ready}, 32'd0);
    n = 1;
    while (!cap_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("zero_ready_cycle", n, 26);
    check("zero_len", rx_q.size(), 25);
    pack_rx(0, got);
    pack_rx(1, lasts);
    check("zero_bits", {7'd0, got}, 32'd0);
    check("zero_last", {7'd0, lasts}, 32'd1);
    check("zero_frame_cnt", {24'd0, frame_cnt}, 32'd1);

    // Directed pattern: Product=0110, Sum=1, tag 0.
    reset_dut();
    run_frame(4'b0110, 4'b0000, 13'b1_0000_0000_0000, 0, got);
    check("req033_bits", {7'd0, got}, {7'd0, 25'b000_0110_0000_1_000000000000_1});

    // Backpressure 1,0,0,1 yields the same stream as ready tied high.
    p = 4'($urandom_range(0, 15)); d = 4'($urandom_range(0, 15)); f = 13'($urandom_range(0, 8191));
    reset_dut();
    run_frame(p, d, f, 0, got);
    reset_dut();
    run_frame(p, d, f, 1, got_b);
    check("bp_same_stream", {7'd0, got_b}, {7'd0, got});

    // Random frames; enough of them to wrap frame_cnt past 255.
    for (int i = 0; i < 262; i++) begin
      run_frame(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                13'($urandom_range(0, 8191)), (i < 16) ? 2 : 0, got);
    end

    // Nine back-to-back frames with cap_valid held high: 26-cycle period.
    reset_dut();
    @(negedge clk);
    cap_valid = 1'b1; ser_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      scramble_inputs();
      fr = {tag_m, product, decoder_y, flags};
      for (int i = 23; i >= 0; i--) exp_q.push_back({1'b0, fr[i]});
      exp_q.push_back({1'b1, ^fr});
      tag_m++;
      @(posedge clk); #1;
      scramble_inputs();
      repeat (25) @(posedge clk);
      @(negedge clk);
    end
    cap_valid = 1'b0;
    compare_queue("b2b_bit");
    check("b2b_frame_cnt", {24'd0, frame_cnt}, 32'd9);

    // Reset in the middle of a frame.
    reset_dut();
    @(negedge clk);
    scramble_inputs();
    cap_valid = 1'b1;
    @(posedge clk); #1;
    cap_valid = 1'b0;
    n = 0;
    while (rx_q.size() < 10 && n < 100) begin
      @(negedge clk);
      n++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_ser_valid", {31'd0, ser_valid}, 32'd0);
    check("midrst_ser_data", {31'd0, ser_data}, 32'd0);
    check("midrst_ser_last", {31'd0, ser_last}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_frame_cnt", {24'd0, frame_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rx_q.delete(); exp_q.delete();
    tag_m = 3'd0; fcnt_m = 8'd0;
    repeat (4) @(posedge clk);
    #1;
    check("midrst_no_stale", rx_q.size(), 0);
    check("midrst_cap_ready", {31'd0, cap_ready}, 32'd1);
    run_frame(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              13'($urandom_range(0, 8191)), 2, got);

    // Parity-free build: Storing=1 only, 24 bits, last on the final data bit.
    @(negedge clk);
    product = 4'd0; decoder_y = 4'd0; flags = 13'd1; cap_valid_np = 1'b1;
    fr = {3'd0, product, decoder_y, flags};
    @(posedge clk); #1;
    cap_valid_np = 1'b0;
    n = 0;
    while (rx_np_q.size() < 24 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    check("np_len", rx_np_q.size(), 24);
    np_bits = '0; np_last = '0;
    for (int i = 0; i < rx_np_q.size() && i < 24; i++) begin
      np_bits[23-i] = rx_np_q[i][0];
      np_last[23-i] = rx_np_q[i][1];
    end
    check("np_bits", {8'd0, np_bits}, {8'd0, fr});
    check("np_last", {8'd0, np_last}, 32'd1);
    check("np_frame_cnt", {24'd0, frame_cnt_np}, 32'd1);
    check("np_cap_ready", {31'd0, cap_ready_np}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
